mips_pipeline_exmem_control: RTL

MIPS_PIPELINE_EXMEM_CONTROL -- requirements
Module: Mips_Pipeline_ExMem_control

---
 rtl/mips_pipeline_exmem_control.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mips_pipeline_exmem_control.sv
// EX/MEM boundary control: sequences single-cycle and iterative mult/div instructions
// into the ExMem register, stalling the front end while the iterative unit runs.
module mips_pipeline_exmem_control #(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       exValid,
   input  logic [1:0] exKind,
   input  logic       memStall,
   input  logic       flush,
   output logic       exMemLoad,
   output logic       exMemBubble,
   output logic       exStall,
   output logic       unitStart,
   output logic       unitAbort,
   output logic       busy,
   output logic [5:0] cycleCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
   localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

   state_t     state_q, state_d;
   logic [5:0] count_q, count_d;
   logic       is_iter;
   logic       is_div;

   // Kind 11 is reserved and falls through as single-cycle.
   assign is_iter = (exKind == 2'b01) || (exKind == 2'b10);
   assign is_div  = (exKind == 2'b10);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      exMemLoad   = !memStall;
      exMemBubble = 1'b1;
      exStall     = 1'b0;
      unitStart   = 1'b0;
      unitAbort   = 1'b0;
      busy        = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            count_d = 6'd0;
            if (!flush && exValid) begin
               if (is_iter) begin
                  exStall = 1'b1;
                  if (!memStall) begin
                     unitStart = 1'b1;
                     count_d   = is_div ? DIV_LOAD : MULT_LOAD;
                     state_d   = RUN;
                  end
               end else begin
                  exMemBubble = 1'b0;
                  exStall     = memStall;
               end
            end
         end
         RUN: begin
            // Flush takes priority over the counter reaching its last cycle.
            if (flush) begin
               unitAbort = 1'b1;
               count_d   = 6'd0;
               state_d   = IDLE;
            end else begin
               exStall = 1'b1;
               if (count_q <= 6'd1) begin
                  count_d = 6'd0;
                  state_d = DONE;
               end else begin
                  count_d = count_q - 6'd1;
               end
            end
         end
         DONE: begin
            if (flush) begin
               unitAbort = 1'b1;
               count_d   = 6'd0;
               state_d   = IDLE;
            end else begin
               exMemBubble = 1'b0;
               exStall     = memStall;
               if (!memStall) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            count_d = 6'd0;
            state_d = IDLE;
         end
      endcase

      // Reset silences every pulse and pushes bubbles into MEM, even mid-RUN.
      if (reset) begin
         exMemLoad   = 1'b1;
         exMemBubble = 1'b1;
         exStall     = 1'b0;
         unitStart   = 1'b0;
         unitAbort   = 1'b0;
         busy        = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= 6'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign cycleCount = count_q;

endmodule
